encryptor_decryptor: RTL and testbench

- Sequential Vigenère-style byte cipher engine that merges the team's encryptor and decryptor into one block, selected by a mode input.
- Takes a MSG_LEN-byte message and a SEC_LEN-byte secret key.
- Shifts ASCII letters by key-derived offsets, one character per clock, and passes all non-letter bytes through unchanged.
- Sits between message buffers and the transport path; encrypt followed by decrypt with the same key must restore the original message exactly.

---
 rtl/encryptor_decryptor.sv | 156 +++++++++++++++
 tb/tb_encryptor_decryptor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/encryptor_decryptor.sv
// Sequential Vigenere-style byte cipher (encrypt/decrypt by mode), one character per clock.
// Define DIGIT_ROTATE_EN to also rotate '0'..'9' by the key offset mod 10.
module encryptor_decryptor #(
   parameter int MSG_LEN = 6,
   parameter int SEC_LEN = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 mode,
   input  logic [SEC_LEN*8-1:0] key_in,
   input  logic [MSG_LEN*8-1:0] text_in,
   output logic [MSG_LEN*8-1:0] text_out,
   output logic                 busy,
   output logic                 done
);

   localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int KEY_W = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PROC,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [KEY_W-1:0]     kidx_q, kidx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [MSG_LEN*8-1:0] out_q, out_d;
   logic                 cap_en;

   logic [MSG_LEN*8-1:0] text_q;
   logic [SEC_LEN*8-1:0] key_q;
   logic                 mode_q;

   function automatic logic [4:0] key_shift(input logic [7:0] k);
      logic [4:0] s;
      s = 5'd0;
      if (k >= 8'h41 && k <= 8'h5A) s = 5'(k - 8'h41);
      else if (k >= 8'h61 && k <= 8'h7A) s = 5'(k - 8'h61);
      return s;
   endfunction

   // Rotate c within [base, base+m) by s; signed 7-bit keeps -25..50 without overflow.
   function automatic logic [7:0] rot(input logic [7:0] c, input logic [7:0] base,
                                      input logic [4:0] s, input logic [4:0] m,
                                      input logic dec);
      logic signed [6:0] pos, sh, mod_s, v;
      pos   = $signed({2'b00, 5'(c - base)});
      sh    = $signed({2'b00, s});
      mod_s = $signed({2'b00, m});
      v     = dec ? (pos - sh) : (pos + sh);
      if (v < 7'sd0) v = v + mod_s;
      else if (v >= mod_s) v = v - mod_s;
      return base + {1'b0, v};
   endfunction

`ifdef DIGIT_ROTATE_EN
   function automatic logic [4:0] mod10(input logic [4:0] s);
      logic [4:0] r;
      if (s >= 5'd20) r = s - 5'd20;
      else if (s >= 5'd10) r = s - 5'd10;
      else r = s;
      return r;
   endfunction
`endif

   function automatic logic [7:0] cipher_byte(input logic [7:0] c, input logic [7:0] k,
                                              input logic dec);
      logic [4:0] s;
      logic [7:0] r;
      s = key_shift(k);
      r = c;
      if (c >= 8'h41 && c <= 8'h5A) r = rot(c, 8'h41, s, 5'd26, dec);
      else if (c >= 8'h61 && c <= 8'h7A) r = rot(c, 8'h61, s, 5'd26, dec);
`ifdef DIGIT_ROTATE_EN
      if (c >= 8'h30 && c <= 8'h39) r = rot(c, 8'h30, mod10(s), 5'd10, dec);
`endif
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      kidx_d  = kidx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      out_d   = out_q;
      cap_en  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cap_en  = 1'b1;
               state_d = S_PROC;
               idx_d   = '0;
               kidx_d  = '0;
               busy_d  = 1'b1;
            end
         end
         S_PROC: begin
            out_d[idx_q*8 +: 8] = cipher_byte(text_q[idx_q*8 +: 8], key_q[kidx_q*8 +: 8], mode_q);
            kidx_d = (kidx_q == KEY_W'(SEC_LEN - 1)) ? '0 : kidx_q + 1'b1;
            if (idx_q == IDX_W'(MSG_LEN - 1)) begin
               state_d = S_DONE;
               idx_d   = '0;
               busy_d  = 1'b0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         kidx_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         kidx_q  <= kidx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         out_q   <= out_d;
      end
   end

   // Operands are only consumed in PROC after a capture, so they need no reset.
   always_ff @(posedge clk) begin
      if (cap_en) begin
         text_q <= text_in;
         key_q  <= key_in;
         mode_q <= mode;
      end
   end

   assign text_out = out_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_encryptor_decryptor.sv
// Directed bench for encryptor_decryptor with a per-cycle behavioural model check.
module tb_encryptor_decryptor;

   localparam int MSG_LEN = 6;
   localparam int SEC_LEN = 7;
   localparam int TW      = MSG_LEN * 8;
   localparam int KW      = SEC_LEN * 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [KW-1:0] key_in = '0;
   logic [TW-1:0] text_in = '0;
   logic [TW-1:0] text_out;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   encryptor_decryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .key_in(key_in),
      .text_in(text_in), .text_out(text_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pack(input string s);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
      return r;
   endfunction

   // Reference cipher straight from the character rules, using integer mod arithmetic.
   function automatic logic [TW-1:0] model(input logic [TW-1:0] t, input logic [KW-1:0] k,
                                           input bit dec);
      logic [TW-1:0] r;
      for (int i = 0; i < MSG_LEN; i++) begin
         int c, kc, s, o;
         c  = int'(t[8*i +: 8]);
         kc = int'(k[8*(i % SEC_LEN) +: 8]);
         if (kc >= 65 && kc <= 90) s = kc - 65;
         else if (kc >= 97 && kc <= 122) s = kc - 97;
         else s = 0;
         o = c;
         if (c >= 65 && c <= 90) o = 65 + (c - 65 + (dec ? 26 - s : s)) % 26;
         else if (c >= 97 && c <= 122) o = 97 + (c - 97 + (dec ? 26 - s : s)) % 26;
`ifdef DIGIT_ROTATE_EN
         else if (c >= 48 && c <= 57) o = 48 + (c - 48 + (dec ? 10 - s % 10 : s % 10)) % 10;
`endif
         r[8*i +: 8] = 8'(o);
      end
      return r;
   endfunction

   // Timeline model: n=0 idle, 1..MSG_LEN processing, MSG_LEN+1 finishing.
   int            n = 0;
   logic [TW-1:0] exp_out = '0;
   logic [TW-1:0] res = '0;
   bit            exp_done = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n = 0; exp_out = '0; exp_done = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (n == 0) begin
            if (start) begin
               res = model(text_in, key_in, mode);
               n = 1;
            end
         end else if (n <= MSG_LEN) begin
            exp_out[8*(n-1) +: 8] = res[8*(n-1) +: 8];
            n++;
         end else begin
            n = 0;
            exp_done = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("mon_text_out", 64'(text_out), 64'(exp_out));
         chk("mon_busy", 64'(busy), 64'(n >= 1 && n <= MSG_LEN));
         chk("mon_done", 64'(done), 64'(exp_done));
      end
   end

   task automatic run_op(input string t, input string k, input bit m, input string expv,
                         input string name, input bit restart);
      int cycles;
      text_in = TW'(pack(t));
      key_in  = KW'(pack(k));
      mode    = m;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      text_in = TW'(pack("qqqqqq"));
      key_in  = KW'(pack("ZZZZZZZ"));
      mode    = ~m;
      cycles  = 0;
      while (!done && cycles < 20) begin
         @(posedge clk); #1;
         cycles++;
         if (restart && cycles == 2) begin
            text_in = TW'(pack("ZZZZZZ"));
            start   = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk({name, "_latency"}, 64'(cycles), 64'(MSG_LEN + 1));
      chk({name, "_text"}, 64'(text_out), 64'(TW'(pack(expv))));
   endtask

   initial begin
      logic [TW-1:0] held;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_text_out", 64'(text_out), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("model_pin", 64'(model(TW'(pack("HELLOZ")), KW'(pack("BBBBBBB")), 1'b0)),
          64'(TW'(pack("IFMMPA"))));
      mon_en = 1'b1;

      run_op("@ $%^&", "HARDSEC", 1'b0, "@ $%^&", "special_enc", 1'b0);
      run_op("@ $%^&", "HARDSEC", 1'b1, "@ $%^&", "special_dec", 1'b0);
      run_op("HELLOZ", "BBBBBBB", 1'b0, "IFMMPA", "upper_enc", 1'b0);
      run_op("IFMMPA", "BBBBBBB", 1'b1, "HELLOZ", "upper_dec_restart", 1'b1);
      run_op("abcxyz", "ABCDEFG", 1'b0, "aceace", "lower_enc", 1'b0);
      run_op("aceace", "ABCDEFG", 1'b1, "abcxyz", "lower_dec", 1'b0);
      run_op("zzzzzz", "a?Cdefg", 1'b0, "zzbcde", "mixed_key", 1'b0);
`ifdef DIGIT_ROTATE_EN
      run_op("123@@@", "BBBBBBB", 1'b0, "234@@@", "digits_enc", 1'b0);
      run_op("234@@@", "BBBBBBB", 1'b1, "123@@@", "digits_dec", 1'b0);
`else
      run_op("123@@@", "BBBBBBB", 1'b0, "123@@@", "digits_enc", 1'b0);
      run_op("123@@@", "BBBBBBB", 1'b1, "123@@@", "digits_dec", 1'b0);
`endif
      held = text_out;
      text_in = TW'(pack("AAAAAA"));
      repeat (4) @(posedge clk);
      #1 chk("hold_after_done", 64'(text_out), 64'(held));

      // Abort mid-operation with an asynchronous reset.
      text_in = TW'(pack("HELLOZ"));
      key_in  = KW'(pack("BBBBBBB"));
      mode    = 1'b0;
      start   = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_text_out", 64'(text_out), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (8) @(posedge clk);
      #1 chk("abort_no_done", 64'(done), 64'd0);
      run_op("Hello!", "KEYKEYK", 1'b0, "Rijvs!", "after_abort", 1'b0);

      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
